bus_load: RTL and testbench

BUS_LOAD -- requirements
Module: bus_load

---
 rtl/bus_load_pkg.sv | 28 ++
 rtl/bus_load_dm_write_fsm.sv | 52 +++++
 rtl/bus_load.sv | 103 ++++++++++
 tb/tb_bus_load.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bus_load_pkg.sv
// Shared definitions for the bus-load datapath and the bus source-select block:
// destination codes, increment bit indices, register widths and the memory-write FSM encoding.
package bus_load_pkg;

    localparam int unsigned REG8_W  = 8;
    localparam int unsigned REG16_W = 16;
    localparam int unsigned CODE_W  = 3;

    localparam logic [CODE_W-1:0] WR_NONE = 3'd0;
    localparam logic [CODE_W-1:0] WR_AR   = 3'd1;
    localparam logic [CODE_W-1:0] WR_PC   = 3'd2;
    localparam logic [CODE_W-1:0] WR_DR   = 3'd3;
    localparam logic [CODE_W-1:0] WR_TR   = 3'd4;
    localparam logic [CODE_W-1:0] WR_R    = 3'd5;
    localparam logic [CODE_W-1:0] WR_AC   = 3'd6;
    localparam logic [CODE_W-1:0] WR_DM   = 3'd7;

    localparam int unsigned INC_AR = 0;
    localparam int unsigned INC_PC = 1;
    localparam int unsigned INC_R  = 2;

    typedef enum logic [1:0] {
        DM_IDLE  = 2'd0,
        DM_SETUP = 2'd1,
        DM_WRITE = 2'd2
    } dm_state_t;

endpackage

// File: rtl/bus_load_dm_write_fsm.sv
// Data-memory write sequencer: a fixed three-cycle IDLE -> SETUP -> WRITE handshake.
//   state | meaning
//   IDLE  | no write pending, new request accepted
//   SETUP | address/data stable, strobe not yet asserted
//   WRITE | dm_we asserted for exactly one cycle
module dm_write_fsm
    import bus_load_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic dm_we
);

    dm_state_t state;
    dm_state_t state_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        dm_we      = 1'b0;
        case (state)
            DM_IDLE: begin
                if (start) begin
                    state_next = DM_SETUP;
                end
            end
            DM_SETUP: begin
                busy       = 1'b1;
                state_next = DM_WRITE;
            end
            DM_WRITE: begin
                busy       = 1'b1;
                dm_we      = 1'b1;
                state_next = DM_IDLE;
            end
            default: begin
                state_next = DM_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/bus_load.sv
// Bus-load datapath: loads architectural registers from the shared bus, handles increments and
// launches data-memory writes. Optional ac-zero flag z is built only with AC_ZERO_FLAG_EN.
module bus_load
    import bus_load_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CODE_W-1:0]    write_en,
    input  logic [REG16_W-1:0]   busin,
    input  logic [2:0]           inc_en,
    output logic [REG8_W-1:0]    ar,
    output logic [REG8_W-1:0]    pc,
    output logic [REG8_W-1:0]    dr,
    output logic [REG8_W-1:0]    r,
    output logic [REG16_W-1:0]   tr,
    output logic [REG16_W-1:0]   ac,
    output logic [REG8_W-1:0]    dm_addr,
    output logic [REG8_W-1:0]    dm_wdata,
    output logic                 dm_we,
    output logic                 busy
`ifdef AC_ZERO_FLAG_EN
    ,
    output logic                 z
`endif
);

    logic [CODE_W-1:0] load_sel;
    logic              dm_start;
    logic              inc_ar;

    // Requests arriving mid-write are dropped outright, never queued.
    always_comb begin
        load_sel = busy ? WR_NONE : write_en;
        dm_start = (load_sel == WR_DM);
        inc_ar   = inc_en[INC_AR] && !busy;
    end

    dm_write_fsm u_dm_write_fsm (
        .clock (clock),
        .reset (reset),
        .start (dm_start),
        .busy  (busy),
        .dm_we (dm_we)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            ar       <= '0;
            pc       <= '0;
            dr       <= '0;
            r        <= '0;
            tr       <= '0;
            ac       <= '0;
            dm_addr  <= '0;
            dm_wdata <= '0;
        end else begin
            if (load_sel == WR_AR) begin
                ar <= busin[REG8_W-1:0];
            end else if (inc_ar) begin
                ar <= ar + 8'd1;
            end

            if (load_sel == WR_PC) begin
                pc <= busin[REG8_W-1:0];
            end else if (inc_en[INC_PC]) begin
                pc <= pc + 8'd1;
            end

            if (load_sel == WR_R) begin
                r <= busin[REG8_W-1:0];
            end else if (inc_en[INC_R]) begin
                r <= r + 8'd1;
            end

            if (load_sel == WR_DR) begin
                dr <= busin[REG8_W-1:0];
            end
            if (load_sel == WR_TR) begin
                tr <= busin;
            end
            if (load_sel == WR_AC) begin
                ac <= busin;
            end

            // Address is the pre-increment ar of the request cycle.
            if (dm_start) begin
                dm_addr  <= ar;
                dm_wdata <= busin[REG8_W-1:0];
            end
        end
    end

`ifdef AC_ZERO_FLAG_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            z <= 1'b1;
        end else if (load_sel == WR_AC) begin
            z <= (busin == '0);
        end
    end
`endif

endmodule

// File: tb/tb_bus_load.sv
// Directed self-checking bench for bus_load; z checks are compiled in only with AC_ZERO_FLAG_EN.
module tb_bus_load;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  write_en;
    logic [15:0] busin;
    logic [2:0]  inc_en;
    logic [7:0]  ar, pc, dr, r, dm_addr, dm_wdata;
    logic [15:0] tr, ac;
    logic        dm_we, busy;
`ifdef AC_ZERO_FLAG_EN
    logic        z;
`endif

    int tests  = 0;
    int failed = 0;

    bus_load dut (
        .clock    (clock),
        .reset    (reset),
        .write_en (write_en),
        .busin    (busin),
        .inc_en   (inc_en),
        .ar       (ar),
        .pc       (pc),
        .dr       (dr),
        .r        (r),
        .tr       (tr),
        .ac       (ac),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_we    (dm_we),
        .busy     (busy)
`ifdef AC_ZERO_FLAG_EN
        ,
        .z        (z)
`endif
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; write_en = 3'd0; busin = 16'h0000; inc_en = 3'b000;
        step();
        step();
        reset = 1'b0;
        check("rst_ar", {8'h0, ar}, 16'h0000);
        check("rst_pc", {8'h0, pc}, 16'h0000);
        check("rst_ac", ac, 16'h0000);
        check("rst_busy", {15'h0, busy}, 16'h0000);
        check("rst_dm_we", {15'h0, dm_we}, 16'h0000);
`ifdef AC_ZERO_FLAG_EN
        check("rst_z", {15'h0, z}, 16'h0001);
`endif

        write_en = 3'd6; busin = 16'h1234;
        step();
        write_en = 3'd0;
        check("ac_load", ac, 16'h1234);
`ifdef AC_ZERO_FLAG_EN
        check("z_nonzero", {15'h0, z}, 16'h0000);
`endif

        write_en = 3'd2; busin = 16'h00FF;
        step();
        write_en = 3'd0;
        check("pc_load_ff", {8'h0, pc}, 16'h00FF);
        inc_en = 3'b010;
        step();
        check("pc_wrap", {8'h0, pc}, 16'h0000);
        // load beats increment on pc; ar and r increment alongside
        write_en = 3'd2; busin = 16'h0040; inc_en = 3'b111;
        step();
        write_en = 3'd0; inc_en = 3'b000;
        check("pc_load_prio", {8'h0, pc}, 16'h0040);
        check("ar_inc_parallel", {8'h0, ar}, 16'h0001);
        check("r_inc_parallel", {8'h0, r}, 16'h0001);

        write_en = 3'd1; busin = 16'h0010;
        step();
        check("ar_load", {8'h0, ar}, 16'h0010);
        write_en = 3'd7; busin = 16'h00AB;
        step();
        check("setup_busy", {15'h0, busy}, 16'h0001);
        check("setup_dm_we", {15'h0, dm_we}, 16'h0000);
        check("setup_addr", {8'h0, dm_addr}, 16'h0010);
        check("setup_wdata", {8'h0, dm_wdata}, 16'h00AB);
        write_en = 3'd3; busin = 16'h0055; inc_en = 3'b101;
        step();
        check("write_busy", {15'h0, busy}, 16'h0001);
        check("write_dm_we", {15'h0, dm_we}, 16'h0001);
        check("write_addr", {8'h0, dm_addr}, 16'h0010);
        check("write_wdata", {8'h0, dm_wdata}, 16'h00AB);
        check("busy_dr_ignored", {8'h0, dr}, 16'h0000);
        check("busy_r_inc", {8'h0, r}, 16'h0002);
        check("busy_ar_hold", {8'h0, ar}, 16'h0010);
        step();
        check("idle_busy", {15'h0, busy}, 16'h0000);
        check("idle_dm_we", {15'h0, dm_we}, 16'h0000);
        check("idle_dr_ignored", {8'h0, dr}, 16'h0000);
        check("idle_r", {8'h0, r}, 16'h0003);
        check("idle_ar", {8'h0, ar}, 16'h0010);

        // a second write request during busy is dropped, not queued
        write_en = 3'd7; busin = 16'h00CD; inc_en = 3'b000;
        step();
        busin = 16'h00EE;
        step();
        step();
        write_en = 3'd0;
        check("noq_busy", {15'h0, busy}, 16'h0000);
        check("noq_wdata", {8'h0, dm_wdata}, 16'h00CD);
        step();
        check("noq_still_idle", {15'h0, busy}, 16'h0000);
        check("hold_wdata", {8'h0, dm_wdata}, 16'h00CD);

        write_en = 3'd7; busin = 16'h0077;
        step();
        write_en = 3'd0;
        check("abort_setup_busy", {15'h0, busy}, 16'h0001);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", {15'h0, busy}, 16'h0000);
        check("abort_dm_we", {15'h0, dm_we}, 16'h0000);
        check("abort_ar", {8'h0, ar}, 16'h0000);
        check("abort_r", {8'h0, r}, 16'h0000);
        check("abort_ac", ac, 16'h0000);
        check("abort_dm_addr", {8'h0, dm_addr}, 16'h0000);
        check("abort_dm_wdata", {8'h0, dm_wdata}, 16'h0000);
        step();
        check("abort_no_retry_we", {15'h0, dm_we}, 16'h0000);
        check("abort_no_retry_busy", {15'h0, busy}, 16'h0000);

        write_en = 3'd6; busin = 16'h0005;
        step();
        check("ac_load_5", ac, 16'h0005);
`ifdef AC_ZERO_FLAG_EN
        check("z_after_5", {15'h0, z}, 16'h0000);
`endif
        busin = 16'h0000;
        step();
        check("ac_load_0", ac, 16'h0000);
`ifdef AC_ZERO_FLAG_EN
        check("z_after_0", {15'h0, z}, 16'h0001);
`endif
        write_en = 3'd4; busin = 16'h1111;
        step();
        write_en = 3'd0;
        check("tr_load", tr, 16'h1111);
        check("ac_hold_tr", ac, 16'h0000);
`ifdef AC_ZERO_FLAG_EN
        check("z_hold_tr", {15'h0, z}, 16'h0001);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
